// File: rtl/sha1_core_unrolled_if.sv
// Command/result bundle for the SHA-1/SHA-0 compression core.
// The master drives a command and a block; the slave returns the digest.
interface sha1_core_unrolled_if;
   localparam int unsigned BLOCK_W  = 512;
   localparam int unsigned DIGEST_W = 160;

   logic                init;
   logic                next;
   logic                sha0_mode;
   logic                abort;
   logic [BLOCK_W-1:0]  block;
   logic                ready;
   logic [DIGEST_W-1:0] digest;
   logic                digest_valid;

   modport master (
      output init, next, sha0_mode, abort, block,
      input  ready, digest, digest_valid
   );

   modport slave (
      input  init, next, sha0_mode, abort, block,
      output ready, digest, digest_valid
   );
endinterface

// File: rtl/sha1_core_unrolled.sv
// SHA-1 / SHA-0 compression core: one 512-bit block per command, UNROLL rounds per
// clock, with an in-place 16-word sliding message schedule.
module sha1_core_unrolled #(
   parameter int unsigned UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sha1_core_unrolled_if.slave  bus
);
   localparam int unsigned WW  = 32;
   localparam int unsigned NH  = 5;
   localparam int unsigned WIN = 16;
   localparam int unsigned EXT = WIN + UNROLL;
   localparam int unsigned CW  = 7;
   localparam logic [CW-1:0] LAST_CTR = CW'(80 - UNROLL);
   localparam logic [WW-1:0] IV [NH] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                         32'h10325476, 32'hc3d2e1f0};

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
      $fatal(1, "sha1_core_unrolled: UNROLL must be 1, 2, 4 or 5");
   end

   typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

   state_t          state, state_nxt;
   logic [WW-1:0]   h   [NH];
   logic [WW-1:0]   st  [NH];
   logic [WW-1:0]   rnd [NH];
   logic [WW-1:0]   w   [WIN];
   logic [WW-1:0]   ext [EXT];
   logic [CW-1:0]   round_ctr;
   logic            mode;
   logic            digest_valid_q;
   logic            accept, run, finish;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.init || bus.next) state_nxt = ROUNDS;
         ROUNDS:  if (bus.abort)                 state_nxt = IDLE;
                  else if (round_ctr == LAST_CTR) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Abort suppresses both round progress and the final H update.
   always_comb begin
      accept = 1'b0;
      run    = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE:    accept = bus.init || bus.next;
         ROUNDS:  run    = !bus.abort;
         DONE:    finish = !bus.abort;
         default: ;
      endcase
   end

   // Window extended by UNROLL new words; later words may use ones made this cycle.
   always_comb begin
      logic [WW-1:0] e_loc [EXT];
      logic [WW-1:0] x;
      x = '0;
      for (int i = 0; i < WIN; i++) e_loc[i] = w[i];
      for (int k = 0; k < UNROLL; k++) begin
         x = e_loc[k+13] ^ e_loc[k+8] ^ e_loc[k+2] ^ e_loc[k];
         e_loc[WIN+k] = mode ? x : {x[WW-2:0], x[WW-1]};
      end
      ext = e_loc;
   end

   always_comb begin
      logic [WW-1:0] v [NH];
      logic [WW-1:0] f, k, tmp;
      logic [CW-1:0] t;
      f   = '0;
      k   = '0;
      tmp = '0;
      t   = '0;
      for (int n = 0; n < NH; n++) v[n] = st[n];
      for (int j = 0; j < UNROLL; j++) begin
         t = round_ctr + CW'(j);
         if (t < CW'(20)) begin
            f = (v[1] & v[2]) | (~v[1] & v[3]);
            k = 32'h5a827999;
         end else if (t < CW'(40)) begin
            f = v[1] ^ v[2] ^ v[3];
            k = 32'h6ed9eba1;
         end else if (t < CW'(60)) begin
            f = (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]);
            k = 32'h8f1bbcdc;
         end else begin
            f = v[1] ^ v[2] ^ v[3];
            k = 32'hca62c1d6;
         end
         tmp  = {v[0][WW-6:0], v[0][WW-1:WW-5]} + v[4] + f + k + ext[j];
         v[4] = v[3];
         v[3] = v[2];
         v[2] = {v[1][1:0], v[1][WW-1:2]};
         v[1] = v[0];
         v[0] = tmp;
      end
      rnd = v;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int n = 0; n < NH; n++) begin
            h[n]  <= '0;
            st[n] <= '0;
         end
         for (int i = 0; i < WIN; i++) w[i] <= '0;
         round_ctr      <= '0;
         mode           <= 1'b0;
         digest_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            for (int n = 0; n < NH; n++) begin
               st[n] <= bus.init ? IV[n] : h[n];
               if (bus.init) h[n] <= IV[n];
            end
            for (int i = 0; i < WIN; i++) w[i] <= bus.block[511 - WW*i -: WW];
            mode           <= bus.sha0_mode;
            round_ctr      <= '0;
            digest_valid_q <= 1'b0;
         end
         if (run) begin
            for (int n = 0; n < NH; n++) st[n] <= rnd[n];
            for (int i = 0; i < WIN; i++) w[i] <= ext[i+UNROLL];
            round_ctr <= round_ctr + CW'(UNROLL);
         end
         if (finish) begin
            for (int n = 0; n < NH; n++) h[n] <= h[n] + st[n];
            digest_valid_q <= 1'b1;
         end
      end
   end

   assign bus.ready        = (state == IDLE);
   assign bus.digest       = {h[0], h[1], h[2], h[3], h[4]};
   assign bus.digest_valid = digest_valid_q;
endmodule

// File: tb/tb_sha1_core_unrolled.sv
// Bench for sha1_core_unrolled: four instances (UNROLL 1,2,4,5) checked every cycle
// against a block-level SHA model, plus directed vectors with published digests.
module tb_sha1_core_unrolled;
   localparam int U_TAB   [4] = '{1, 2, 4, 5};
   localparam int LAT_TAB [4] = '{82, 42, 22, 18};
   localparam logic [159:0] IV       = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
   localparam logic [159:0] ABC_DIG  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] SHA0_DIG = 160'h0164b8a9_14cd2a5e_74c4f7ff_082c4d97_f1edf880;
   localparam logic [159:0] TWO_DIG  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
   localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] M1_BLK   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] M2_BLK   = {480'h0, 32'h000001c0};

   logic clk, reset_n;
   logic         init_s [4], next_s [4], mode_s [4], abort_s [4];
   logic [511:0] blk_s  [4];
   logic         rdy_s  [4], val_s [4];
   logic [159:0] dig_s  [4];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      sha1_core_unrolled_if bus ();
      assign bus.init      = init_s[g];
      assign bus.next      = next_s[g];
      assign bus.sha0_mode = mode_s[g];
      assign bus.abort     = abort_s[g];
      assign bus.block     = blk_s[g];
      assign rdy_s[g]      = bus.ready;
      assign val_s[g]      = bus.digest_valid;
      assign dig_s[g]      = bus.digest;
      sha1_core_unrolled #(.UNROLL(U_TAB[g])) dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus.slave)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Full compression of one block from chaining value hin, feed-forward included.
   function automatic logic [159:0] sha_comp(input logic [159:0] hin, input logic [511:0] blk,
                                             input logic m);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, tmp, x;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 80; t++) begin
         x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
         w[t] = m ? x : {x[30:0], x[31]};
      end
      a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
      for (int t = 0; t < 80; t++) begin
         if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
         else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
         else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
         else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
         tmp = {a[26:0], a[31:27]} + e + f + k + w[t];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
      end
      return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
   endfunction

   // Block-level model: busy for 80/U round cycles plus one finish cycle.
   logic         mbusy [4], mval [4];
   logic [159:0] mh [4], mres [4];
   int           mcnt [4];

   always @(posedge clk) begin : model
      logic [159:0] start;
      for (int i = 0; i < 4; i++) begin
         if (!reset_n) begin
            mbusy[i] = 1'b0; mval[i] = 1'b0; mh[i] = '0; mcnt[i] = 0;
         end else if (!mbusy[i]) begin
            if (init_s[i] || next_s[i]) begin
               start = init_s[i] ? IV : mh[i];
               if (init_s[i]) mh[i] = IV;
               mres[i]  = sha_comp(start, blk_s[i], mode_s[i]);
               mcnt[i]  = 80 / U_TAB[i] + 1;
               mbusy[i] = 1'b1;
               mval[i]  = 1'b0;
            end
         end else if (abort_s[i]) begin
            mbusy[i] = 1'b0;
         end else begin
            mcnt[i]--;
            if (mcnt[i] == 0) begin
               mh[i]    = mres[i];
               mval[i]  = 1'b1;
               mbusy[i] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdy_s[i] !== !mbusy[i]) begin
            errors++;
            $display("FAIL ready u%0d @%0t: got %b expected %b", U_TAB[i], $time, rdy_s[i], !mbusy[i]);
         end
         checks++;
         if (val_s[i] !== mval[i]) begin
            errors++;
            $display("FAIL digest_valid u%0d @%0t: got %b expected %b", U_TAB[i], $time, val_s[i], mval[i]);
         end
         checks++;
         if (dig_s[i] !== mh[i]) begin
            errors++;
            $display("FAIL digest u%0d @%0t: got %h expected %h", U_TAB[i], $time, dig_s[i], mh[i]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int i, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s u%0d: got %h expected %h", name, U_TAB[i], got, exp);
      end
   endtask

   task automatic issue(input int i, input bit is_init, input logic [511:0] b, input bit m);
      chk("ready_before_cmd", i, 160'(rdy_s[i]), 160'd1);
      blk_s[i]  = b;
      mode_s[i] = m;
      if (is_init) init_s[i] = 1'b1;
      else         next_s[i] = 1'b1;
      step();
      init_s[i] = 1'b0;
      next_s[i] = 1'b0;
      mode_s[i] = ~m;
      blk_s[i]  = ~b;
   endtask

   // Edge count includes the accepting edge.
   task automatic wait_valid(input int i, output int lat);
      lat = 1;
      while (!val_s[i] && lat < 400) begin
         step();
         lat++;
      end
      if (lat >= 400) chk("valid_timeout", i, 160'(val_s[i]), 160'd1);
   endtask

   task automatic reset_pulse();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   initial begin : stim
      int lat;
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         init_s[i] = 1'b0; next_s[i] = 1'b0; mode_s[i] = 1'b0; abort_s[i] = 1'b0; blk_s[i] = '0;
      end
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) chk("reset_digest", i, dig_s[i], 160'h0);

      for (int i = 0; i < 4; i++) begin
         issue(i, 1'b1, ABC_BLK, 1'b0);
         wait_valid(i, lat);
         chk("abc_latency", i, 160'(lat), 160'(LAT_TAB[i]));
         chk("abc_digest", i, dig_s[i], ABC_DIG);

         issue(i, 1'b1, ABC_BLK, 1'b1);
         wait_valid(i, lat);
         chk("sha0_digest", i, dig_s[i], SHA0_DIG);

         issue(i, 1'b1, M1_BLK, 1'b0);
         wait_valid(i, lat);
         issue(i, 1'b0, M2_BLK, 1'b0);
         wait_valid(i, lat);
         chk("two_block_latency", i, 160'(lat), 160'(LAT_TAB[i]));
         chk("two_block_digest", i, dig_s[i], TWO_DIG);

         // Abort at round 40 of a continuation block: H keeps the "abc" digest.
         issue(i, 1'b1, ABC_BLK, 1'b0);
         wait_valid(i, lat);
         issue(i, 1'b0, ABC_BLK, 1'b0);
         repeat (40 / U_TAB[i]) step();
         abort_s[i] = 1'b1;
         step();
         abort_s[i] = 1'b0;
         chk("abort_r40_ready", i, 160'(rdy_s[i]), 160'd1);
         chk("abort_r40_valid", i, 160'(val_s[i]), 160'd0);
         chk("abort_r40_h", i, dig_s[i], ABC_DIG);

         // Abort during the finish cycle beats the H update.
         issue(i, 1'b0, ABC_BLK, 1'b0);
         repeat (80 / U_TAB[i]) step();
         abort_s[i] = 1'b1;
         step();
         abort_s[i] = 1'b0;
         chk("abort_done_valid", i, 160'(val_s[i]), 160'd0);
         chk("abort_done_h", i, dig_s[i], ABC_DIG);

         // init pulsed mid-rounds with a different block is ignored.
         issue(i, 1'b1, ABC_BLK, 1'b0);
         repeat (3) step();
         init_s[i] = 1'b1;
         blk_s[i]  = M1_BLK;
         step();
         init_s[i] = 1'b0;
         wait_valid(i, lat);
         chk("busy_init_ignored", i, dig_s[i], ABC_DIG);

         // Reset around round 30, then a fresh init.
         issue(i, 1'b1, ABC_BLK, 1'b0);
         repeat ((30 + U_TAB[i] - 1) / U_TAB[i]) step();
         reset_pulse();
         chk("midreset_ready", i, 160'(rdy_s[i]), 160'd1);
         chk("midreset_valid", i, 160'(val_s[i]), 160'd0);
         chk("midreset_digest", i, dig_s[i], 160'h0);
         issue(i, 1'b1, ABC_BLK, 1'b0);
         wait_valid(i, lat);
         chk("after_reset_latency", i, 160'(lat), 160'(LAT_TAB[i]));
         chk("after_reset_digest", i, dig_s[i], ABC_DIG);
         repeat (2) step();
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
